hazard_ctrl: RTL

Pipeline hazard controller for the 5-stage RISC-V core. It generates the per-stage `en`/`clr` controls consumed by every pipeline register (PC, F/D, D/E, E/M, M/W), the E-stage forwarding selects, and a stall-cycle performance count. It handles four cases:
- load-use stalls;
- taken-branch flushes;
- fixed-latency multiply/divide (MDU) occupancy of E;
- variable-latency data-memory waits in M.

---
 rtl/riscv_pkg.sv | 12 +
 rtl/hazard_fwd.sv | 16 +
 rtl/hazard_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types for the pipeline hazard controller
package riscv_pkg;
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;
    typedef enum logic {
        RUN,
        MDU_BUSY
    } hz_state_t;
endpackage

// File: rtl/hazard_fwd.sv
// hazard_fwd: combinational operand forwarding select for one E-stage source
module hazard_fwd
    import riscv_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic       regwrite_m,
    input  logic       regwrite_w,
    output fwd_sel_t   fwd
);
    logic hit_m, hit_w;
    assign hit_m = regwrite_m && rd_m != 5'd0 && rd_m == rs;
    assign hit_w = regwrite_w && rd_w != 5'd0 && rd_w == rs;
    assign fwd = hit_m ? FWD_MEM : hit_w ? FWD_WB : FWD_RF;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: per-stage enable/flush generation, forwarding selects and
// stall counting for the 5-stage core
module hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int MDU_LATENCY = 4,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rs1_e,
    input  logic [4:0]       rs2_e,
    input  logic [4:0]       rd_e,
    input  logic [4:0]       rd_m,
    input  logic [4:0]       rd_w,
    input  logic             regwrite_m,
    input  logic             regwrite_w,
    input  logic             load_e,
    input  logic             mdu_e,
    input  logic             branch_taken_e,
    input  logic             dmem_req_m,
    input  logic             dmem_ack,
    output logic [1:0]       fwd_a_e,
    output logic [1:0]       fwd_b_e,
    output logic             en_pc,
    output logic             en_fd,
    output logic             en_de,
    output logic             en_em,
    output logic             en_mw,
    output logic             clr_fd,
    output logic             clr_de,
    output logic             clr_em,
    output logic             clr_mw,
    output logic [CNT_W-1:0] stall_cycles
);
    localparam int CW = $clog2(MDU_LATENCY);
    fwd_sel_t fwd_a, fwd_b;
    hz_state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic mem_stall, lu_stall, mdu_hold;
    hazard_fwd u_fwd_a (
        .rs(rs1_e), .rd_m(rd_m), .rd_w(rd_w),
        .regwrite_m(regwrite_m), .regwrite_w(regwrite_w), .fwd(fwd_a)
    );
    hazard_fwd u_fwd_b (
        .rs(rs2_e), .rd_m(rd_m), .rd_w(rd_w),
        .regwrite_m(regwrite_m), .regwrite_w(regwrite_w), .fwd(fwd_b)
    );
    assign fwd_a_e = fwd_a;
    assign fwd_b_e = fwd_b;
    assign mem_stall = dmem_req_m && !dmem_ack;
    assign lu_stall = load_e && rd_e != 5'd0 && (rd_e == rs1_d || rd_e == rs2_d);
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end
    // cnt keeps running through memory waits; only the release waits for them
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        mdu_hold = 1'b0;
        if (state == RUN) begin
            if (mdu_e && !mem_stall) begin
                mdu_hold = 1'b1;
                state_nx = MDU_BUSY;
                cnt_nx   = CW'(MDU_LATENCY - 2);
            end
        end else if (cnt != '0) begin
            mdu_hold = 1'b1;
            cnt_nx   = cnt - 1'b1;
        end else if (mem_stall) begin
            mdu_hold = 1'b1;
        end else begin
            state_nx = RUN;
        end
    end
    always_comb begin
        {en_pc, en_fd, en_de, en_em, en_mw} = 5'b11111;
        {clr_fd, clr_de, clr_em, clr_mw} = 4'b0000;
        if (rst) begin
            {clr_fd, clr_de, clr_em, clr_mw} = 4'b1111;
        end else if (mem_stall) begin
            {en_pc, en_fd, en_de, en_em, en_mw} = 5'b00000;
            clr_mw = 1'b1;
        end else begin
            if (mdu_hold) begin
                {en_pc, en_fd, en_de} = 3'b000;
                clr_em = 1'b1;
            end else if (lu_stall) begin
                {en_pc, en_fd} = 2'b00;
                clr_de = 1'b1;
            end
            if (branch_taken_e) {clr_fd, clr_de} = 2'b11;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) stall_cycles <= '0;
        else if (!en_pc) stall_cycles <= stall_cycles + 1'b1;
    end
endmodule
